// File: rtl/count2watch_pkg.sv
// count2watch_pkg: shared constants, field widths and FSM state type
// for the millisecond-to-wall-clock converter.
package count2watch_pkg;

    // Divisors for each stage of the breakdown
    localparam int MS_PER_HR  = 3600000;
    localparam int MS_PER_MIN = 60000;
    localparam int MS_PER_SEC = 1000;

    // Output field widths
    localparam int HR_W  = 4;
    localparam int MIN_W = 7;
    localparam int SEC_W = 7;
    localparam int MS_W  = 11;

    // Hour quotient at or above this value no longer fits the hr field
    localparam int HR_LIMIT = 16;

    // Clamp values used when saturation is enabled (15:59:59.999)
    localparam logic [HR_W-1:0]  SAT_HR  = 4'd15;
    localparam logic [MIN_W-1:0] SAT_MIN = 7'd59;
    localparam logic [SEC_W-1:0] SAT_SEC = 7'd59;
    localparam logic [MS_W-1:0]  SAT_MS  = 11'd999;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DIV_HR  = 3'd1,
        DIV_MIN = 3'd2,
        DIV_SEC = 3'd3,
        DONE    = 3'd4
    } state_e;

endpackage

// File: rtl/const_divider.sv
// const_divider: BITS-cycle restoring shift/subtract divider.
// A start pulse loads the dividend and performs the first step on the same
// edge; ready is high during the cycle whose closing edge performs the last
// step, so quotient/remainder are final in the cycle after ready.
module const_divider
    import count2watch_pkg::*;
#(
    parameter int BITS = 26
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [BITS-1:0] divisor,
    input  logic [BITS-1:0] dividend,
    output logic [BITS-1:0] quotient,
    output logic [BITS-1:0] remainder,
    output logic            ready
);

    localparam int CNT_W = $clog2(BITS + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BITS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q, run_d;
    logic [BITS-1:0]  quo_q, quo_d;
    logic [BITS-1:0]  rem_q, rem_d;
    logic [BITS-1:0]  num_q, num_d;

    logic [BITS-1:0]  src_r;
    logic [BITS-1:0]  src_n;
    logic [BITS:0]    trial;
    logic             qbit;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor when it fits
    always_comb begin
        quo_d = quo_q;
        rem_d = rem_q;
        num_d = num_q;
        src_r = start ? '0 : rem_q;
        src_n = start ? dividend : num_q;
        trial = {src_r, src_n[BITS-1]};
        qbit  = (trial >= {1'b0, divisor});
        if (start || run_q) begin
            if (qbit) begin
                rem_d = BITS'(trial - {1'b0, divisor});
            end else begin
                rem_d = BITS'(trial);
            end
            if (start) begin
                quo_d = {{(BITS-1){1'b0}}, qbit};
            end else begin
                quo_d = {quo_q[BITS-2:0], qbit};
            end
            num_d = {src_n[BITS-2:0], 1'b0};
        end
    end

    // Step counter: start counts as step one, finish after BITS steps
    always_comb begin
        cnt_d = cnt_q;
        run_d = run_q;
        if (start) begin
            cnt_d = CNT_W'(1);
            run_d = 1'b1;
        end else if (run_q) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_STEP) begin
                cnt_d = '0;
                run_d = 1'b0;
            end
        end
    end

    // Control state with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    // Datapath registers, no reset needed
    always_ff @(posedge clk) begin
        quo_q <= quo_d;
        rem_q <= rem_d;
        num_q <= num_d;
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign ready     = run_q && (cnt_q == LAST_STEP);

endmodule

// File: rtl/count_to_watch.sv
// count_to_watch: converts an unsigned millisecond count into hr/min/s/ms
// using one shared iterative divider in three successive stages.
// Optional macro COUNT2WATCH_SAT_EN: clamp results to 15:59:59.999 when the
// hour quotient reaches 16; otherwise hr wraps modulo 16. ovf is reported
// in both builds.
module count_to_watch
    import count2watch_pkg::*;
#(
    parameter int BITS = 26
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [BITS-1:0]  count,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [HR_W-1:0]  hr,
    output logic [MIN_W-1:0] min,
    output logic [SEC_W-1:0] s,
    output logic [MS_W-1:0]  ms
);

    state_e state_q, state_d;
    logic   first_q, first_d;

    logic [BITS-1:0]  cap_q, cap_d;
    logic [HR_W-1:0]  hr_lo_q, hr_lo_d;
    logic             hr_big_q, hr_big_d;
    logic [MIN_W-1:0] min_raw_q, min_raw_d;

    logic [HR_W-1:0]  hr_q, hr_d;
    logic [MIN_W-1:0] min_q, min_d;
    logic [SEC_W-1:0] s_q, s_d;
    logic [MS_W-1:0]  ms_q, ms_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic [BITS-1:0]  div_divisor;
    logic [BITS-1:0]  div_dividend;
    logic [BITS-1:0]  div_quo;
    logic [BITS-1:0]  div_rem;
    logic             div_ready;

    // Divisor and dividend selection for the active stage; later stages
    // consume the remainder left by the previous one
    always_comb begin
        div_divisor  = BITS'(MS_PER_SEC);
        div_dividend = div_rem;
        case (state_q)
            DIV_HR: begin
                div_divisor  = BITS'(MS_PER_HR);
                div_dividend = cap_q;
            end
            DIV_MIN: div_divisor = BITS'(MS_PER_MIN);
            default: div_divisor = BITS'(MS_PER_SEC);
        endcase
    end

    const_divider #(
        .BITS(BITS)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (first_q),
        .divisor  (div_divisor),
        .dividend (div_dividend),
        .quotient (div_quo),
        .remainder(div_rem),
        .ready    (div_ready)
    );

    // Next-state, stage result capture and output update
    always_comb begin
        state_d   = state_q;
        cap_d     = cap_q;
        hr_lo_d   = hr_lo_q;
        hr_big_d  = hr_big_q;
        min_raw_d = min_raw_q;
        hr_d      = hr_q;
        min_d     = min_q;
        s_d       = s_q;
        ms_d      = ms_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    cap_d   = count;
                    state_d = DIV_HR;
                end
            end
            DIV_HR: begin
                if (div_ready) state_d = DIV_MIN;
            end
            DIV_MIN: begin
                // Hour quotient is final during the first cycle of this stage
                if (first_q) begin
                    hr_lo_d  = div_quo[HR_W-1:0];
                    hr_big_d = (div_quo >= BITS'(HR_LIMIT));
                end
                if (div_ready) state_d = DIV_SEC;
            end
            DIV_SEC: begin
                if (first_q) min_raw_d = div_quo[MIN_W-1:0];
                if (div_ready) state_d = DONE;
            end
            DONE: begin
                done_d = 1'b1;
                ovf_d  = hr_big_q;
`ifdef COUNT2WATCH_SAT_EN
                if (hr_big_q) begin
                    hr_d  = SAT_HR;
                    min_d = SAT_MIN;
                    s_d   = SAT_SEC;
                    ms_d  = SAT_MS;
                end else begin
                    hr_d  = hr_lo_q;
                    min_d = min_raw_q;
                    s_d   = div_quo[SEC_W-1:0];
                    ms_d  = div_rem[MS_W-1:0];
                end
`else
                hr_d  = hr_lo_q;
                min_d = min_raw_q;
                s_d   = div_quo[SEC_W-1:0];
                ms_d  = div_rem[MS_W-1:0];
`endif
                // A load here starts the next conversion back-to-back
                if (load) begin
                    cap_d   = count;
                    state_d = DIV_HR;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Divider start fires on the first cycle of each divide stage
    always_comb begin
        first_d = (state_d != state_q) &&
                  ((state_d == DIV_HR) || (state_d == DIV_MIN) || (state_d == DIV_SEC));
    end

    // Control and visible outputs, cleared by asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            first_q <= 1'b0;
            hr_q    <= '0;
            min_q   <= '0;
            s_q     <= '0;
            ms_q    <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
            hr_q    <= hr_d;
            min_q   <= min_d;
            s_q     <= s_d;
            ms_q    <= ms_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    // Intermediate stage results, no reset needed
    always_ff @(posedge clk) begin
        cap_q     <= cap_d;
        hr_lo_q   <= hr_lo_d;
        hr_big_q  <= hr_big_d;
        min_raw_q <= min_raw_d;
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign ovf  = ovf_q;
    assign hr   = hr_q;
    assign min  = min_q;
    assign s    = s_q;
    assign ms   = ms_q;

endmodule

// File: tb/tb_count_to_watch.sv
// Directed bench for count_to_watch (BITS=26, latency 79 cycles).
module tb_count_to_watch;

    localparam int BITS = 26;
    localparam int LAT  = 3 * BITS + 1;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            load = 1'b0;
    logic [BITS-1:0] count = '0;
    logic            busy, done, ovf;
    logic [3:0]      hr;
    logic [6:0]      min, s;
    logic [10:0]     ms;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    count_to_watch #(.BITS(BITS)) dut (
        .clk  (clk),
        .reset(reset),
        .load (load),
        .count(count),
        .busy (busy),
        .done (done),
        .ovf  (ovf),
        .hr   (hr),
        .min  (min),
        .s    (s),
        .ms   (ms)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for the next done pulse; n = cycles waited
    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!done && n < 200);
    endtask

    task automatic chk_fields(input string tag, input int eh, input int em,
                              input int es, input int ems, input int eo);
        chk({tag, "_hr"},  32'(hr),  32'(eh));
        chk({tag, "_min"}, 32'(min), 32'(em));
        chk({tag, "_s"},   32'(s),   32'(es));
        chk({tag, "_ms"},  32'(ms),  32'(ems));
        chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
    endtask

    task automatic start_load(input logic [31:0] val);
        @(negedge clk);
        count = val[BITS-1:0];
        load  = 1'b1;
        @(posedge clk);
        #1;
        load  = 1'b0;
    endtask

    task automatic conv(input string tag, input logic [31:0] val, input int eh,
                        input int em, input int es, input int ems, input int eo);
        int n;
        start_load(val);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        wait_done(n);
        chk({tag, "_lat"}, 32'(n), 32'(LAT));
        chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        chk_fields(tag, eh, em, es, ems, eo);
        @(posedge clk);
        #1;
        chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        chk({tag, "_hold_ms"}, 32'(ms), 32'(ems));
    endtask

    initial begin
        int n;
        int pulses;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk_fields("rst", 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;

        // Basic conversions
        conv("c1100", 32'd1100, 0, 0, 1, 100, 0);
        conv("c7200000", 32'd7200000, 2, 0, 0, 0, 0);
        conv("c123548", 32'd123548, 0, 2, 3, 548, 0);
        conv("c0", 32'd0, 0, 0, 0, 0, 0);
`ifdef COUNT2WATCH_SAT_EN
        conv("cmax", 32'd67108863, 15, 59, 59, 999, 1);
`else
        conv("cmax", 32'd67108863, 2, 38, 28, 863, 1);
`endif
        // Just below the 16 h boundary: 57,599,999 = 15:59:59.999, no overflow
        conv("c16h_m1", 32'd57599999, 15, 59, 59, 999, 0);
        // Exactly 16 h overflows
`ifdef COUNT2WATCH_SAT_EN
        conv("c16h", 32'd57600000, 15, 59, 59, 999, 1);
`else
        conv("c16h", 32'd57600000, 0, 0, 0, 0, 1);
`endif

        // Load during conversion is ignored
        start_load(32'd1100);
        repeat (19) @(posedge clk);
        @(negedge clk);
        count = 26'd7200000;
        load  = 1'b1;
        @(posedge clk);
        #1;
        load  = 1'b0;
        wait_done(n);
        chk("ign_lat", 32'(n + 20), 32'(LAT));
        chk_fields("ign", 0, 0, 1, 100, 0);

        // Reset mid-conversion aborts and clears
        start_load(32'd123548);
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk_fields("arst", 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        repeat (100) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        chk("arst_no_done", 32'(pulses), 32'd0);
        chk("arst_idle_busy", 32'(busy), 32'd0);
        conv("post_rst", 32'd123548, 0, 2, 3, 548, 0);

        // Load held high: back-to-back conversions
        @(negedge clk);
        count = 26'd1100;
        load  = 1'b1;
        @(posedge clk);
        #1;
        wait_done(n);
        chk("b2b_first_lat", 32'(n), 32'(LAT));
        chk_fields("b2b0", 0, 0, 1, 100, 0);
        for (int i = 0; i < 2; i++) begin
            wait_done(n);
            chk("b2b_spacing", 32'(n), 32'(LAT));
            chk_fields("b2b", 0, 0, 1, 100, 0);
        end
        @(negedge clk);
        load = 1'b0;
        wait_done(n);
        chk("b2b_last_lat", 32'(n), 32'(LAT));
        @(posedge clk);
        #1;
        chk("b2b_idle", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
